// File: rtl/mult_div_pkg.sv
// Shared opcode encodings and FSM state type for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/mult_div_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    isDiv,
  input  logic [2*DATA_WIDTH-1:0] accum,
  input  logic [DATA_WIDTH-1:0]   mag,
  output logic [2*DATA_WIDTH-1:0] nextAccum
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   addend_s;
  logic [W:0]   sum_s;
  logic [W:0]   shifted_s;
  logic         geq_s;
  logic [W-1:0] remNext_s;

  // Divide keeps {remainder, quotient/dividend}; multiply keeps {partial product, multiplier}.
  always_comb begin
    addend_s  = accum[0] ? {1'b0, mag} : {(W+1){1'b0}};
    sum_s     = {1'b0, accum[2*W-1:W]} + addend_s;
    shifted_s = accum[2*W-1:W-1];
    geq_s     = (shifted_s >= {1'b0, mag});
    // Remainder stays below the divisor, so the difference always fits in W bits.
    if (geq_s) begin
      remNext_s = W'(shifted_s - {1'b0, mag});
    end else begin
      remNext_s = shifted_s[W-1:0];
    end
    if (isDiv) begin
      nextAccum = {remNext_s, accum[W-2:0], geq_s};
    end else begin
      nextAccum = {sum_s, accum[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_Start,
  input  logic [1:0]            in_Op_2,
  input  logic [DATA_WIDTH-1:0] in_A_dw,
  input  logic [DATA_WIDTH-1:0] in_B_dw,
  input  logic                  in_WriteHi,
  input  logic                  in_WriteLo,
  input  logic [DATA_WIDTH-1:0] in_WriteData_dw,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [DATA_WIDTH-1:0] o_Hi_dw,
  output logic [DATA_WIDTH-1:0] o_Lo_dw
);

  localparam int W = DATA_WIDTH;

  state_t               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 isDiv_r;
  logic                 signA_r;
  logic                 signB_r;
  logic [W-1:0]         magA_r;
  logic [W-1:0]         magB_r;
  logic [W-1:0]         aRaw_r;
  logic [2*W-1:0]       accum_r;

  logic                 startSignA_s;
  logic                 startSignB_s;
  logic [W-1:0]         startMagA_s;
  logic [W-1:0]         startMagB_s;
  logic [W-1:0]         stepMag_s;
  logic [2*W-1:0]       nextAccum_s;
  logic [2*W-1:0]       product_s;
  logic [W-1:0]         quo_s;
  logic [W-1:0]         rem_s;
  logic [W-1:0]         hiRes_s;
  logic [W-1:0]         loRes_s;

  // Operand signs only matter for the signed opcodes (opcode bit 0 set).
  always_comb begin
    startSignA_s = in_Op_2[0] & in_A_dw[W-1];
    startSignB_s = in_Op_2[0] & in_B_dw[W-1];
    startMagA_s  = startSignA_s ? -in_A_dw : in_A_dw;
    startMagB_s  = startSignB_s ? -in_B_dw : in_B_dw;
    stepMag_s    = isDiv_r ? magB_r : magA_r;
  end

  mult_div_step #(
    .DATA_WIDTH(W)
  ) uStep (
    .isDiv    (isDiv_r),
    .accum    (accum_r),
    .mag      (stepMag_s),
    .nextAccum(nextAccum_s)
  );

  // Sign correction of the magnitude result, plus the divide-by-zero convention.
  always_comb begin
    product_s = (signA_r ^ signB_r) ? -accum_r : accum_r;
    quo_s     = accum_r[W-1:0];
    rem_s     = accum_r[2*W-1:W];
    hiRes_s   = product_s[2*W-1:W];
    loRes_s   = product_s[W-1:0];
    if (isDiv_r) begin
      if (magB_r == {W{1'b0}}) begin
        hiRes_s = aRaw_r;
        loRes_s = {W{1'b1}};
      end else begin
        hiRes_s = signA_r ? -rem_s : rem_s;
        loRes_s = (signA_r ^ signB_r) ? -quo_s : quo_s;
      end
    end else begin
      hiRes_s = product_s[2*W-1:W];
      loRes_s = product_s[W-1:0];
    end
  end

  // Control FSM, iteration datapath and the HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_WIDTH{1'b0}};
      isDiv_r <= 1'b0;
      signA_r <= 1'b0;
      signB_r <= 1'b0;
      magA_r  <= {W{1'b0}};
      magB_r  <= {W{1'b0}};
      aRaw_r  <= {W{1'b0}};
      accum_r <= {(2*W){1'b0}};
      o_Busy  <= 1'b0;
      o_Done  <= 1'b0;
      o_Hi_dw <= {W{1'b0}};
      o_Lo_dw <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          o_Done <= 1'b0;
          if (in_WriteHi) o_Hi_dw <= in_WriteData_dw;
          if (in_WriteLo) o_Lo_dw <= in_WriteData_dw;
          if (in_Start) begin
            state_r <= CALC;
            cnt_r   <= {CNT_WIDTH{1'b0}};
            isDiv_r <= in_Op_2[1];
            signA_r <= startSignA_s;
            signB_r <= startSignB_s;
            magA_r  <= startMagA_s;
            magB_r  <= startMagB_s;
            aRaw_r  <= in_A_dw;
            accum_r <= in_Op_2[1] ? {{W{1'b0}}, startMagA_s} : {{W{1'b0}}, startMagB_s};
            o_Busy  <= 1'b1;
          end
        end
        CALC: begin
          accum_r <= nextAccum_s;
          cnt_r   <= cnt_r + CNT_WIDTH'(1);
          if (cnt_r == CNT_WIDTH'(W - 1)) state_r <= FIX;
        end
        FIX: begin
          o_Hi_dw <= hiRes_s;
          o_Lo_dw <= loRes_s;
          o_Done  <= 1'b1;
          o_Busy  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          o_Busy  <= 1'b0;
          o_Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (32-bit instance plus an 8-bit instance).
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  opIn;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic        writeHi;
  logic        writeLo;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int vectors;
  int miscompares;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_Start       (start),
    .in_Op_2        (opIn),
    .in_A_dw        (aIn),
    .in_B_dw        (bIn),
    .in_WriteHi     (writeHi),
    .in_WriteLo     (writeLo),
    .in_WriteData_dw(writeData),
    .o_Busy         (busy),
    .o_Done         (done),
    .o_Hi_dw        (hi),
    .o_Lo_dw        (lo)
  );

  mult_div_unit #(.DATA_WIDTH(8)) dut8 (
    .clk            (clk),
    .reset          (reset),
    .in_Start       (start8),
    .in_Op_2        (op8),
    .in_A_dw        (a8),
    .in_B_dw        (b8),
    .in_WriteHi     (1'b0),
    .in_WriteLo     (1'b0),
    .in_WriteData_dw(8'h00),
    .o_Busy         (busy8),
    .o_Done         (done8),
    .o_Hi_dw        (hi8),
    .o_Lo_dw        (lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents an operation for one edge, then scrambles the operand inputs.
  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; opIn = op; aIn = a; bIn = b;
    @(posedge clk);
    #1;
    start = 1'b0; opIn = 2'($urandom); aIn = $urandom; bIn = $urandom;
  endtask

  task automatic finishOp(input string tag, input logic [31:0] expHi, input logic [31:0] expLo,
                          input int pre);
    int cyc;
    cyc = pre;
    @(negedge clk);
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busyCycles"}, 64'(cyc), 64'd33);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, expHi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, expLo});
    @(negedge clk);
    check({tag, "_doneOnePulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int cyc;
    int doneSeen;
    vectors = 0; miscompares = 0;
    reset = 1'b1; start = 1'b0; opIn = 2'b00; aIn = 32'd0; bIn = 32'd0;
    writeHi = 1'b0; writeLo = 1'b0; writeData = 32'd0;
    start8 = 1'b0; op8 = 2'b00; a8 = 8'd0; b8 = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);

    startOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finishOp("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0);

    startOp(2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
    finishOp("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    startOp(2'b01, 32'h8000_0000, 32'h8000_0000);
    finishOp("mult_minmin", 32'h4000_0000, 32'h0000_0000, 0);

    startOp(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    finishOp("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    startOp(2'b10, 32'd100, 32'd7);
    finishOp("divu_100_7", 32'd2, 32'd14, 0);
    startOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    finishOp("div_ovf", 32'h0000_0000, 32'h8000_0000, 0);

    startOp(2'b10, 32'h1234_5678, 32'd0);
    finishOp("divu_by0", 32'h1234_5678, 32'hFFFF_FFFF, 0);
    startOp(2'b11, 32'h1234_5678, 32'd0);
    finishOp("div_by0", 32'h1234_5678, 32'hFFFF_FFFF, 0);

    // Start and MTLO while busy must both be ignored.
    startOp(2'b00, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    check("busy_midop", {63'd0, busy}, 64'd1);
    start = 1'b1; opIn = 2'b10; aIn = 32'd1000; bIn = 32'd9;
    writeLo = 1'b1; writeData = 32'h0000_00AA;
    @(negedge clk);
    start = 1'b0; writeLo = 1'b0;
    finishOp("ignore_busy", 32'd0, 32'd15, 4);

    writeHi = 1'b1; writeData = 32'h0000_0055;
    @(negedge clk);
    writeHi = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h55);
    check("mthi_lo_kept", {32'd0, lo}, 64'd15);

    writeHi = 1'b1; writeLo = 1'b1; writeData = 32'hCAFE_1234;
    @(negedge clk);
    writeHi = 1'b0; writeLo = 1'b0;
    check("mtboth_hi", {32'd0, hi}, 64'hCAFE_1234);
    check("mtboth_lo", {32'd0, lo}, 64'hCAFE_1234);

    // Reset sampled on the tenth step edge aborts the divide.
    startOp(2'b10, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    check("abort_noDone", 64'(doneSeen), 64'd0);

    @(negedge clk);
    start8 = 1'b1; op8 = 2'b01; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'h3C; b8 = 8'h11; op8 = 2'b10;
    cyc = 0;
    @(negedge clk);
    while (busy8 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("w8_busyCycles", 64'(cyc), 64'd9);
    check("w8_done", {63'd0, done8}, 64'd1);
    check("w8_hi", {56'd0, hi8}, 64'h40);
    check("w8_lo", {56'd0, lo8}, 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
